pdata_uart_bridge: RTL and testbench
====================================

PDATA_UART_BRIDGE -- requirements
Module: pdata_uart_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: byte FIFO entries, power of two, range 2..16.
REQ-002 Parameter POLL_GAP, default 8: idle cycles between consecutive status polls, range 1..255.
REQ-003 Port serial_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port parallel_data, input, 2: dibit from the deserializer.
REQ-006 Port pdata_valid, input, 1: parallel_data is valid this cycle.
REQ-007 Port enable, input, 1: 1 = accept dibits and run the CSR master; 0 = hold.
REQ-008 Port uart_csr_address, output, 3: UART CSR register index.
REQ-009 Port uart_csr_chipselect, output, 1: transfer active.
REQ-010 Port uart_csr_read_n, output, 1: active-low read strobe.
REQ-011 Port uart_csr_write_n, output, 1: active-low write strobe.
REQ-012 Port uart_csr_begintransfer, output, 1: first cycle of a transfer.
REQ-013 Port uart_csr_writedata, output, 16: write data.
REQ-014 Port uart_csr_readdata, input, 16: read data.
REQ-015 Port fifo_level, output, 5: current FIFO occupancy.
REQ-016 Port overflow, output, 1: sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-017 Packing: each accepted dibit shifts into a byte, first dibit in bits [7:6], fourth in [1:0].
- Accepted = pdata_valid && enable.
- A dibit counter 0..3 advances per accepted dibit.
- On the fourth dibit the byte is pushed to the FIFO and the counter wraps to 0.
REQ-018 Full FIFO on push: the byte is discarded, overflow sets to 1 on the next edge, and the counter still wraps.
- Only reset clears overflow.
REQ-019 Push and pop in the same cycle: both take effect and fifo_level is unchanged.
- A push to a full FIFO is a drop even if a pop happens in that same cycle.
REQ-020 FSM states: IDLE, POLL, EVAL, GAP, WRITE.
REQ-021 IDLE -> POLL when the FIFO is non-empty and enable=1; otherwise stay in IDLE.
REQ-022 POLL lasts 2 cycles.
- Outputs: address=2, chipselect=1, read_n=0, write_n=1.
- begintransfer=1 in the first cycle only.
- readdata is registered at the end of the second cycle.
- Next state: EVAL.
REQ-023 EVAL lasts 1 cycle with chipselect=0.
- Registered readdata bit 6 (TRDY) = 1 -> WRITE.
- TRDY = 0 -> GAP.
REQ-024 GAP waits POLL_GAP cycles with chipselect=0, then goes to POLL.
REQ-025 WRITE lasts 2 cycles.
- Outputs: address=1, writedata={8'h00, FIFO head}, chipselect=1, write_n=0, read_n=1.
- begintransfer=1 in the first cycle only.
- The FIFO pops at the end of the second cycle.
- Next state: IDLE.
REQ-026 A deasserted enable never aborts a POLL or WRITE already in progress.
- enable=0 blocks only the IDLE -> POLL transition and the GAP -> POLL transition.
REQ-027 Whenever chipselect=0, the outputs are: address=0, writedata=0, read_n=1, write_n=1, begintransfer=0.
REQ-028 All CSR outputs are driven directly from registers, with no combinational path from any input.
REQ-029 Bytes leave the block in arrival order; at most one CSR transfer is outstanding at a time.

Reset
REQ-030 While reset_n=0, all of the following hold:
- FSM in IDLE, dibit counter = 0, FIFO empty, fifo_level = 0, overflow = 0.
- chipselect = 0, read_n = 1, write_n = 1, begintransfer = 0, address = 0, writedata = 0.
REQ-031 Reset asserted mid-transfer drops the outputs to their reset values asynchronously; FIFO contents are lost.

Verification
REQ-032 Dibits 11,00,10,01 with readdata=16'h0040:
- POLL at address 2, then WRITE at address 1 with writedata = 16'h00C9.
- fifo_level goes 1 -> 0.
REQ-033 readdata=16'h0000 for 3 polls, then 16'h0040:
- 4 POLL transfers, each separated by POLL_GAP idle cycles.
- Exactly one WRITE follows the fourth POLL.
REQ-034 TRDY held 0 while 5 bytes arrive (FIFO_DEPTH=4):
- fifo_level = 4 and overflow = 1.
- After TRDY=1, the first 4 bytes are written in order and the 5th is absent.
REQ-035 enable=0 while 4 valid dibits are applied: no push and no transfer; the counter holds its value.
REQ-036 reset_n pulsed low during the WRITE cycle:
- chipselect = 0 immediately and fifo_level = 0.
- No further transfers until new bytes arrive.
REQ-037 A push while WRITE pops a byte (FIFO at level 2): fifo_level stays 2 and no overflow.

Source files
------------

// File: rtl/pdata_uart_bridge_if.sv
// UART CSR bus: the bridge drives it as master, the UART register block answers as slave.
interface pdata_uart_bridge_if;
   logic [2:0]  uart_csr_address;
   logic        uart_csr_chipselect;
   logic        uart_csr_read_n;
   logic        uart_csr_write_n;
   logic        uart_csr_begintransfer;
   logic [15:0] uart_csr_writedata;
   logic [15:0] uart_csr_readdata;

   modport master (
      output uart_csr_address,
      output uart_csr_chipselect,
      output uart_csr_read_n,
      output uart_csr_write_n,
      output uart_csr_begintransfer,
      output uart_csr_writedata,
      input  uart_csr_readdata
   );

   modport slave (
      input  uart_csr_address,
      input  uart_csr_chipselect,
      input  uart_csr_read_n,
      input  uart_csr_write_n,
      input  uart_csr_begintransfer,
      input  uart_csr_writedata,
      output uart_csr_readdata
   );
endinterface

// File: rtl/pdata_uart_bridge.sv
// Packs deserializer dibits into bytes, queues them, and forwards each byte to a UART
// through its CSR port once a status poll reports the transmitter ready (TRDY).
module pdata_uart_bridge #(
   parameter int FIFO_DEPTH = 4,
   parameter int POLL_GAP   = 8
) (
   input  logic                      serial_clk,
   input  logic                      reset_n,
   input  logic [1:0]                parallel_data,
   input  logic                      pdata_valid,
   input  logic                      enable,
   output logic [4:0]                fifo_level,
   output logic                      overflow,
   pdata_uart_bridge_if.master       csr
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {IDLE, POLL, EVAL, GAP, WRITE} state_t;

   state_t          state_reg, state_next;
   logic            phase_reg, phase_next;
   logic [7:0]      gap_reg, gap_next;
   logic            trdy_reg;

   logic [1:0]      dibit_cnt_reg;
   logic [5:0]      shift_reg;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [4:0]      count_reg;
   logic            overflow_reg;

   logic [2:0]      address_reg;
   logic            chipselect_reg, read_n_reg, write_n_reg, begintransfer_reg;
   logic [15:0]     writedata_reg;

   logic accepted, push, full, push_ok, pop;

   assign accepted = pdata_valid && enable;
   assign push     = accepted && (dibit_cnt_reg == 2'd3);
   assign full     = (count_reg == 5'(FIFO_DEPTH));
   assign push_ok  = push && !full;
   assign pop      = (state_reg == WRITE) && phase_reg;

   // Packing and FIFO bookkeeping; a push into a full FIFO is dropped even alongside a pop.
   always_ff @(posedge serial_clk or negedge reset_n) begin
      if (!reset_n) begin
         dibit_cnt_reg <= 2'd0;
         shift_reg     <= 6'd0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= 5'd0;
         overflow_reg  <= 1'b0;
      end else begin
         if (accepted) begin
            dibit_cnt_reg <= dibit_cnt_reg + 2'd1;
            shift_reg     <= {shift_reg[3:0], parallel_data};
         end
         if (push && full)
            overflow_reg <= 1'b1;
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + 5'd1;
            2'b01:   count_reg <= count_reg - 5'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge serial_clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= {shift_reg, parallel_data};
   end

   always_ff @(posedge serial_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         phase_reg <= 1'b0;
         gap_reg   <= 8'd0;
         trdy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         gap_reg   <= gap_next;
         if (state_reg == POLL && phase_reg)
            trdy_reg <= csr.uart_csr_readdata[6];
      end
   end

   always_comb begin
      state_next = state_reg;
      phase_next = 1'b0;
      gap_next   = gap_reg;
      case (state_reg)
         IDLE:  if (count_reg != 5'd0 && enable) state_next = POLL;
         POLL:  if (!phase_reg) begin
                   phase_next = 1'b1;
                end else begin
                   state_next = EVAL;
                end
         EVAL:  begin
                   state_next = trdy_reg ? WRITE : GAP;
                   gap_next   = 8'd0;
                end
         GAP:   if (gap_reg >= 8'(POLL_GAP - 1)) begin
                   if (enable) state_next = POLL;
                end else begin
                   gap_next = gap_reg + 8'd1;
                end
         WRITE: if (!phase_reg) begin
                   phase_next = 1'b1;
                end else begin
                   state_next = IDLE;
                end
         default: state_next = IDLE;
      endcase
   end

   // Bus outputs are registered from the next state so they line up with state_reg.
   always_ff @(posedge serial_clk or negedge reset_n) begin
      if (!reset_n) begin
         address_reg       <= 3'd0;
         chipselect_reg    <= 1'b0;
         read_n_reg        <= 1'b1;
         write_n_reg       <= 1'b1;
         begintransfer_reg <= 1'b0;
         writedata_reg     <= 16'd0;
      end else begin
         address_reg       <= 3'd0;
         chipselect_reg    <= 1'b0;
         read_n_reg        <= 1'b1;
         write_n_reg       <= 1'b1;
         begintransfer_reg <= 1'b0;
         writedata_reg     <= 16'd0;
         if (state_next == POLL) begin
            address_reg       <= 3'd2;
            chipselect_reg    <= 1'b1;
            read_n_reg        <= 1'b0;
            begintransfer_reg <= !phase_next;
         end else if (state_next == WRITE) begin
            address_reg       <= 3'd1;
            chipselect_reg    <= 1'b1;
            write_n_reg       <= 1'b0;
            begintransfer_reg <= !phase_next;
            writedata_reg     <= {8'h00, mem[rd_ptr_reg]};
         end
      end
   end

   assign csr.uart_csr_address       = address_reg;
   assign csr.uart_csr_chipselect    = chipselect_reg;
   assign csr.uart_csr_read_n        = read_n_reg;
   assign csr.uart_csr_write_n       = write_n_reg;
   assign csr.uart_csr_begintransfer = begintransfer_reg;
   assign csr.uart_csr_writedata     = writedata_reg;
   assign fifo_level                 = count_reg;
   assign overflow                   = overflow_reg;
endmodule

// File: tb/tb_pdata_uart_bridge.sv
// Directed bench for pdata_uart_bridge: a negedge monitor logs every CSR transfer and a
// poll-counting UART model answers TRDY; each task checks its scenario against constants.
module tb_pdata_uart_bridge;
   localparam int FIFO_DEPTH = 4;
   localparam int POLL_GAP   = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] parallel_data = 2'b00;
   logic       pdata_valid = 1'b0;
   logic       enable = 1'b0;
   logic [4:0] fifo_level;
   logic       overflow;

   pdata_uart_bridge_if bus ();

   pdata_uart_bridge #(.FIFO_DEPTH(FIFO_DEPTH), .POLL_GAP(POLL_GAP)) dut (
      .serial_clk    (clk),
      .reset_n       (reset_n),
      .parallel_data (parallel_data),
      .pdata_valid   (pdata_valid),
      .enable        (enable),
      .fifo_level    (fifo_level),
      .overflow      (overflow),
      .csr           (bus)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int poll_count = 0;
   int trdy_after = 0;
   int cs_cycles = 0;
   int idle_viol = 0;
   logic [2:0]  q_addr [$];
   logic [15:0] q_data [$];
   bit          q_wr   [$];
   int          q_cyc  [$];

   // UART model: TRDY reads back as 1 once more than trdy_after polls have started.
   assign bus.uart_csr_readdata = (poll_count > trdy_after) ? 16'h0040 : 16'h0000;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (bus.uart_csr_chipselect) begin
         cs_cycles++;
         if (bus.uart_csr_begintransfer) begin
            q_addr.push_back(bus.uart_csr_address);
            q_data.push_back(bus.uart_csr_writedata);
            q_wr.push_back(!bus.uart_csr_write_n);
            q_cyc.push_back(cyc);
            if (!bus.uart_csr_read_n) poll_count++;
            $display("xfer cyc=%0d addr=%0d wr=%0d wdata=%h level=%0d", cyc,
                     bus.uart_csr_address, !bus.uart_csr_write_n, bus.uart_csr_writedata, fifo_level);
         end
      end else if (bus.uart_csr_address != 3'd0 || bus.uart_csr_writedata != 16'd0 ||
                   !bus.uart_csr_read_n || !bus.uart_csr_write_n || bus.uart_csr_begintransfer) begin
         idle_viol++;
      end
   end

   task automatic clear_log();
      q_addr.delete(); q_data.delete(); q_wr.delete(); q_cyc.delete();
      poll_count = 0; cs_cycles = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset_n = 1'b0; pdata_valid = 1'b0; enable = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      clear_log();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 3; i >= 0; i--) begin
         @(negedge clk);
         parallel_data = b[2*i +: 2];
         pdata_valid = 1'b1;
      end
      @(negedge clk);
      pdata_valid = 1'b0;
   endtask

   task automatic drain(input int budget, output int used);
      used = 0;
      while (used < budget && (fifo_level != 5'd0 || bus.uart_csr_chipselect)) begin
         @(negedge clk);
         used++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (bus.uart_csr_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", bus.uart_csr_chipselect); end
      checks++; if (bus.uart_csr_read_n !== 1'b1) begin errors++; $display("FAIL reset_read_n got=%b exp=1", bus.uart_csr_read_n); end
      checks++; if (bus.uart_csr_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n got=%b exp=1", bus.uart_csr_write_n); end
      checks++; if (bus.uart_csr_begintransfer !== 1'b0) begin errors++; $display("FAIL reset_bt got=%b exp=0", bus.uart_csr_begintransfer); end
      checks++; if (bus.uart_csr_address !== 3'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.uart_csr_address); end
      checks++; if (bus.uart_csr_writedata !== 16'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0000", bus.uart_csr_writedata); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int used;
      reset_dut();
      trdy_after = 0;
      send_byte(8'hC9);
      checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL basic_level_after_push got=%0d exp=1", fifo_level); end
      drain(40, used);
      checks++; if (used >= 40) begin errors++; $display("FAIL basic_drain_timeout got=%0d exp<40", used); end
      checks++;
      if (q_addr.size() != 2) begin
         errors++; $display("FAIL basic_xfer_count got=%0d exp=2", q_addr.size());
      end else begin
         checks++; if (q_addr[0] !== 3'd2 || q_wr[0]) begin errors++; $display("FAIL basic_poll got addr=%0d wr=%0d exp addr=2 wr=0", q_addr[0], q_wr[0]); end
         checks++; if (q_addr[1] !== 3'd1 || !q_wr[1] || q_data[1] !== 16'h00C9) begin errors++; $display("FAIL basic_write got addr=%0d wdata=%h exp addr=1 wdata=00c9", q_addr[1], q_data[1]); end
         checks++; if (q_cyc[1] - q_cyc[0] != 3) begin errors++; $display("FAIL basic_poll_to_write got=%0d exp=3", q_cyc[1] - q_cyc[0]); end
      end
      checks++; if (cs_cycles != 4) begin errors++; $display("FAIL basic_cs_cycles got=%0d exp=4", cs_cycles); end
      checks++; if (idle_viol != 0) begin errors++; $display("FAIL basic_idle_outputs got=%0d exp=0", idle_viol); end
   endtask

   task automatic test_poll_gap();
      int used;
      reset_dut();
      trdy_after = 3;
      send_byte(8'hA5);
      drain(150, used);
      checks++; if (used >= 150) begin errors++; $display("FAIL gap_drain_timeout got=%0d exp<150", used); end
      checks++;
      if (q_addr.size() != 5) begin
         errors++; $display("FAIL gap_xfer_count got=%0d exp=5", q_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (q_addr[i] !== 3'd2 || q_wr[i]) begin errors++; $display("FAIL gap_poll%0d got addr=%0d wr=%0d exp addr=2 wr=0", i, q_addr[i], q_wr[i]); end
         end
         // Poll starts are 2 POLL cycles + 1 EVAL cycle + POLL_GAP GAP cycles apart.
         for (int i = 1; i < 4; i++) begin
            checks++; if (q_cyc[i] - q_cyc[i-1] != POLL_GAP + 3) begin errors++; $display("FAIL gap_spacing%0d got=%0d exp=%0d", i, q_cyc[i] - q_cyc[i-1], POLL_GAP + 3); end
         end
         checks++; if (!q_wr[4] || q_data[4] !== 16'h00A5 || q_cyc[4] - q_cyc[3] != 3) begin errors++; $display("FAIL gap_write got wr=%0d wdata=%h dist=%0d exp wr=1 wdata=00a5 dist=3", q_wr[4], q_data[4], q_cyc[4] - q_cyc[3]); end
      end
      checks++; if (idle_viol != 0) begin errors++; $display("FAIL gap_idle_outputs got=%0d exp=0", idle_viol); end
   endtask

   task automatic test_overflow();
      int used;
      logic [15:0] wr_list [$];
      logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      reset_dut();
      trdy_after = 1000000;
      for (int i = 0; i < 4; i++) send_byte(bytes[i]);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      send_byte(bytes[4]);
      checks++; if (fifo_level !== 5'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      trdy_after = poll_count;
      drain(200, used);
      checks++; if (used >= 200) begin errors++; $display("FAIL ovf_drain_timeout got=%0d exp<200", used); end
      for (int i = 0; i < q_wr.size(); i++) if (q_wr[i]) wr_list.push_back(q_data[i]);
      checks++;
      if (wr_list.size() != 4) begin
         errors++; $display("FAIL ovf_write_count got=%0d exp=4", wr_list.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (wr_list[i] !== {8'h00, bytes[i]}) begin errors++; $display("FAIL ovf_order%0d got=%h exp=%h", i, wr_list[i], {8'h00, bytes[i]}); end
         end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_enable_hold();
      int used;
      reset_dut();
      trdy_after = 0;
      @(negedge clk); parallel_data = 2'b10; pdata_valid = 1'b1;
      @(negedge clk); parallel_data = 2'b11;
      @(negedge clk); enable = 1'b0; parallel_data = 2'b00;
      repeat (4) @(negedge clk);
      pdata_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (fifo_level !== 5'd0 || q_addr.size() != 0) begin errors++; $display("FAIL en_hold got level=%0d xfers=%0d exp level=0 xfers=0", fifo_level, q_addr.size()); end
      enable = 1'b1; parallel_data = 2'b01; pdata_valid = 1'b1;
      @(negedge clk); parallel_data = 2'b10;
      @(negedge clk); pdata_valid = 1'b0; enable = 1'b0;
      checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL en_resume_push got=%0d exp=1", fifo_level); end
      repeat (10) @(negedge clk);
      checks++; if (q_addr.size() != 0 || fifo_level !== 5'd1) begin errors++; $display("FAIL en_block_poll got xfers=%0d level=%0d exp xfers=0 level=1", q_addr.size(), fifo_level); end
      enable = 1'b1;
      drain(40, used);
      checks++;
      if (q_addr.size() != 2) begin
         errors++; $display("FAIL en_xfer_count got=%0d exp=2", q_addr.size());
      end else begin
         checks++; if (!q_wr[1] || q_data[1] !== 16'h00B6) begin errors++; $display("FAIL en_write got wr=%0d wdata=%h exp wr=1 wdata=00b6", q_wr[1], q_data[1]); end
      end
   endtask

   task automatic test_reset_mid_write();
      int n;
      int used;
      reset_dut();
      trdy_after = 0;
      send_byte(8'h5A);
      send_byte(8'h0F);
      for (n = 0; n < 40 && !(bus.uart_csr_chipselect && !bus.uart_csr_write_n); n++) @(negedge clk);
      checks++; if (n >= 40) begin errors++; $display("FAIL rst_wait_write_timeout got=%0d exp<40", n); end
      reset_n = 1'b0;
      #1;
      checks++; if (bus.uart_csr_chipselect !== 1'b0 || bus.uart_csr_write_n !== 1'b1) begin errors++; $display("FAIL rst_async_cs got cs=%b write_n=%b exp cs=0 write_n=1", bus.uart_csr_chipselect, bus.uart_csr_write_n); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_async_level got=%0d exp=0", fifo_level); end
      @(negedge clk);
      reset_n = 1'b1;
      clear_log();
      repeat (30) @(negedge clk);
      checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL rst_no_xfer got=%0d exp=0", q_addr.size()); end
      send_byte(8'h3C);
      drain(40, used);
      checks++;
      if (q_addr.size() != 2) begin
         errors++; $display("FAIL rst_new_xfer_count got=%0d exp=2", q_addr.size());
      end else begin
         checks++; if (!q_wr[1] || q_data[1] !== 16'h003C) begin errors++; $display("FAIL rst_new_write got wr=%0d wdata=%h exp wr=1 wdata=003c", q_wr[1], q_data[1]); end
      end
   endtask

   task automatic test_push_pop();
      int n;
      int used;
      logic [15:0] wr_list [$];
      reset_dut();
      trdy_after = 1000000;
      send_byte(8'h5A);
      send_byte(8'h0F);
      @(negedge clk); parallel_data = 2'b11; pdata_valid = 1'b1;
      @(negedge clk); parallel_data = 2'b10;
      @(negedge clk); parallel_data = 2'b01;
      @(negedge clk); pdata_valid = 1'b0;
      checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL pp_level_before got=%0d exp=2", fifo_level); end
      trdy_after = poll_count;
      for (n = 0; n < 60 && !(bus.uart_csr_chipselect && !bus.uart_csr_write_n && !bus.uart_csr_begintransfer); n++) @(negedge clk);
      checks++; if (n >= 60) begin errors++; $display("FAIL pp_wait_timeout got=%0d exp<60", n); end
      checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL pp_level_at_pop got=%0d exp=2", fifo_level); end
      parallel_data = 2'b00; pdata_valid = 1'b1;
      @(negedge clk); pdata_valid = 1'b0;
      checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL pp_level_after got=%0d exp=2", fifo_level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
      drain(120, used);
      for (int i = 0; i < q_wr.size(); i++) if (q_wr[i]) wr_list.push_back(q_data[i]);
      checks++;
      if (wr_list.size() != 3) begin
         errors++; $display("FAIL pp_write_count got=%0d exp=3", wr_list.size());
      end else begin
         checks++; if (wr_list[0] !== 16'h005A || wr_list[1] !== 16'h000F || wr_list[2] !== 16'h00E4) begin errors++; $display("FAIL pp_order got=%h %h %h exp=005a 000f 00e4", wr_list[0], wr_list[1], wr_list[2]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_poll_gap();
      test_overflow();
      test_enable_hold();
      test_reset_mid_write();
      test_push_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
